tvip_axi_sample_latency_fifo: RTL

//  Elastic valid/ready buffer for one AXI channel in the sample environment: holds up to DEPTH beats, each
//  for a runtime-programmable minimum latency before it is offered downstream. Order is preserved.

---
 rtl/tvip_axi_sample_pkg.sv | 16 +
 rtl/tvip_axi_sample_latency_timer.sv | 38 +++
 rtl/tvip_axi_sample_latency_fifo.sv | 132 +++++++++++++
 3 files changed

// File: rtl/tvip_axi_sample_pkg.sv
// Shared constants, types and helpers for the sample-environment latency FIFO.
package tvip_axi_sample_pkg;

    localparam int DEFAULT_DATA_WIDTH    = 32;
    localparam int DEFAULT_DEPTH         = 4;
    localparam int DEFAULT_LATENCY_WIDTH = 8;
    localparam int STATS_COUNTER_WIDTH   = 32;

    typedef logic [DEFAULT_LATENCY_WIDTH-1:0] tvip_axi_sample_latency;
    typedef logic [STATS_COUNTER_WIDTH-1:0]   stats_counter_t;

    function automatic stats_counter_t stats_sat_inc(input stats_counter_t value);
        return (&value) ? value : value + STATS_COUNTER_WIDTH'(1);
    endfunction

endpackage

// File: rtl/tvip_axi_sample_latency_timer.sv
// Per-entry hold timer: loaded at push, counts down to zero and stays there.
module tvip_axi_sample_latency_timer
    import tvip_axi_sample_pkg::*;
#(
    parameter int LATENCY_WIDTH = DEFAULT_LATENCY_WIDTH
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_load,
    input  logic [LATENCY_WIDTH-1:0] i_latency,
    output logic                     o_expired
);

    // One extra bit: the load value is latency+1 so a beat is never visible in its push cycle.
    logic [LATENCY_WIDTH:0] timer_q, timer_d;

    always_comb begin
        // NOTE: default first so every path assigns timer_d and no latch is inferred.
        timer_d = timer_q;
        if (i_load) begin
            timer_d = (LATENCY_WIDTH+1)'(i_latency) + (LATENCY_WIDTH+1)'(1);
        end else if (timer_q != '0) begin
            timer_d = timer_q - (LATENCY_WIDTH+1)'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end

    assign o_expired = (timer_q == '0);

endmodule

// File: rtl/tvip_axi_sample_latency_fifo.sv
// Elastic valid/ready buffer that holds each beat a programmable number of cycles, in order.
// Optional statistics outputs are enabled by defining TVIP_AXI_SAMPLE_LATENCY_STATS_EN.
module tvip_axi_sample_latency_fifo
    import tvip_axi_sample_pkg::*;
#(
    parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
    parameter int DEPTH         = DEFAULT_DEPTH,
    parameter int LATENCY_WIDTH = DEFAULT_LATENCY_WIDTH
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_enable,
    input  logic [LATENCY_WIDTH-1:0]     i_latency,
    input  logic                         i_valid,
    output logic                         o_ready,
    input  logic [DATA_WIDTH-1:0]        i_d,
    output logic                         o_valid,
    input  logic                         i_ready,
    output logic [DATA_WIDTH-1:0]        o_d,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
`ifdef TVIP_AXI_SAMPLE_LATENCY_STATS_EN
    ,
    output logic [$clog2(DEPTH+1)-1:0]   o_max_count,
    output logic [STATS_COUNTER_WIDTH-1:0] o_hold_cycles
`endif
);

    localparam int CW = $clog2(DEPTH+1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_PTR   = PW'(DEPTH-1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [DEPTH-1:0]      expired;
    logic [DEPTH-1:0]      load;
    logic                  fifo_ready, fifo_valid, push, pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
        return (ptr == LAST_PTR) ? '0 : ptr + PW'(1);
    endfunction

    for (genvar i = 0; i < DEPTH; i++) begin : g_timer
        assign load[i] = push && (wr_ptr_q == PW'(i));

        tvip_axi_sample_latency_timer #(
            .LATENCY_WIDTH (LATENCY_WIDTH)
        ) u_timer (
            .i_clk     (i_clk),
            .i_rst     (i_rst),
            .i_load    (load[i]),
            .i_latency (i_latency),
            .o_expired (expired[i])
        );
    end

    // Full blocks push even when the head leaves this cycle: no ready path from i_ready.
    always_comb begin
        fifo_ready = (count_q != FULL_COUNT);
        fifo_valid = (count_q != '0) && expired[rd_ptr_q];
        push       = i_enable && i_valid && fifo_ready;
        pop        = i_enable && fifo_valid && i_ready;

        o_ready = i_enable ? fifo_ready       : i_ready;
        o_valid = i_enable ? fifo_valid       : i_valid;
        o_d     = i_enable ? mem_q[rd_ptr_q]  : i_d;
        o_count = count_q;
    end

    always_comb begin
        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is reset so o_d is defined (zero) after reset; drop the reset only if that is relaxed.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[wr_ptr_q] <= i_d;
        end
    end

`ifdef TVIP_AXI_SAMPLE_LATENCY_STATS_EN
    logic [CW-1:0]  max_count_q;
    stats_counter_t hold_cycles_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            max_count_q   <= '0;
            hold_cycles_q <= '0;
        end else begin
            if (count_d > max_count_q) begin
                max_count_q <= count_d;
            end
            if ((count_q != '0) && !fifo_valid) begin
                hold_cycles_q <= stats_sat_inc(hold_cycles_q);
            end
        end
    end

    assign o_max_count   = max_count_q;
    assign o_hold_cycles = hold_cycles_q;
`endif

    // Switching mode with beats in flight would strand or duplicate them.
    enable_change_only_when_empty: assert property (
        @(posedge i_clk) disable iff (i_rst) !$stable(i_enable) |-> (count_q == '0)
    );

endmodule
